// File: rtl/parking_pkg.sv
// Shared constants, types and the hour-to-capacity table for the parking controller.
package parking_pkg;

  localparam int unsigned TOTAL_CAPACITY  = 700;
  localparam int unsigned CLOCKS_PER_HOUR = 500;
  localparam int unsigned START_HOUR      = 8;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned HOUR_W = 5;

  localparam int unsigned FREE_CAP_DAY     = 200;
  localparam int unsigned FREE_CAP_H13     = 250;
  localparam int unsigned FREE_CAP_H14     = 300;
  localparam int unsigned FREE_CAP_H15     = 350;
  localparam int unsigned FREE_CAP_EVENING = 500;

  typedef logic [CNT_W-1:0]  count_t;
  typedef logic [HOUR_W-1:0] hour_t;

  // Public spaces grow through the afternoon as university demand drops.
  function automatic count_t free_capacity(input hour_t h);
    count_t cap;
    if (h <= hour_t'(12))      cap = count_t'(FREE_CAP_DAY);
    else if (h == hour_t'(13)) cap = count_t'(FREE_CAP_H13);
    else if (h == hour_t'(14)) cap = count_t'(FREE_CAP_H14);
    else if (h == hour_t'(15)) cap = count_t'(FREE_CAP_H15);
    else                       cap = count_t'(FREE_CAP_EVENING);
    return cap;
  endfunction

endpackage

// File: rtl/parking_hour_clock.sv
// Simulated time of day: divides the system clock into hours and counts 0..23.
module parking_hour_clock
  import parking_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  output hour_t hour_o
);

  localparam int unsigned CYC_W = (CLOCKS_PER_HOUR > 1) ? $clog2(CLOCKS_PER_HOUR) : 1;

  logic [CYC_W-1:0] cyc_q, cyc_d;
  hour_t            hour_q, hour_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cyc_d  = cyc_q + 1'b1;
    hour_d = hour_q;
    if (cyc_q == CYC_W'(CLOCKS_PER_HOUR - 1)) begin
      cyc_d  = '0;
      hour_d = (hour_q == hour_t'(23)) ? '0 : hour_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      hour_q <= hour_t'(START_HOUR);
    end else begin
      cyc_q  <= cyc_d;
      hour_q <= hour_d;
    end
  end

  assign hour_o = hour_q;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking lot occupancy controller: hour-dependent capacity split, per-category
// counts, and refusal flags for full-lot entries and empty-lot exits.
module parking_lot_ctrl
  import parking_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              car_entered,
  input  logic              is_uni_car_entered,
  input  logic              car_exited,
  input  logic              is_uni_car_exited,
  output logic [HOUR_W-1:0] hour,
  output logic [CNT_W-1:0]  uni_parked_car,
  output logic [CNT_W-1:0]  free_parked_car,
  output logic [CNT_W-1:0]  uni_vacated_space,
  output logic [CNT_W-1:0]  free_vacated_space,
  output logic              uni_is_vacated_space,
  output logic              free_is_vacated_space,
  output logic              ja_nist,
  output logic              faulty_exit
);

  hour_t  hour_w;
  count_t free_cap, uni_cap;
  count_t uni_vac, free_vac;
  count_t uni_q, uni_d, free_q, free_d;
  logic   ja_q, ja_d, fe_q, fe_d;
  logic   entry_ok, exit_ok;

  parking_hour_clock u_hour_clock (
    .clk    (clock),
    .rst_n  (reset),
    .hour_o (hour_w)
  );

  assign free_cap = free_capacity(hour_w);
  assign uni_cap  = count_t'(TOTAL_CAPACITY) - free_cap;

  // Capacity can drop below occupancy at an hour change; cars stay, vacancy floors at 0.
  assign uni_vac  = (uni_q  < uni_cap)  ? uni_cap  - uni_q  : '0;
  assign free_vac = (free_q < free_cap) ? free_cap - free_q : '0;

  assign entry_ok = car_entered &&
                    (is_uni_car_entered ? (uni_vac != '0) : (free_vac != '0));
  assign exit_ok  = car_exited &&
                    (is_uni_car_exited ? (uni_q != '0) : (free_q != '0));

  // Both guards use pre-edge counts, so an entry and exit in one category cancel.
  always_comb begin
    uni_d  = uni_q;
    free_d = free_q;
    if (entry_ok) begin
      if (is_uni_car_entered) uni_d  = uni_d + 1'b1;
      else                    free_d = free_d + 1'b1;
    end
    if (exit_ok) begin
      if (is_uni_car_exited) uni_d  = uni_d - 1'b1;
      else                   free_d = free_d - 1'b1;
    end
    ja_d = car_entered && !entry_ok;
    fe_d = car_exited  && !exit_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uni_q  <= '0;
      free_q <= '0;
      ja_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      uni_q  <= uni_d;
      free_q <= free_d;
      ja_q   <= ja_d;
      fe_q   <= fe_d;
    end
  end

  assign hour                  = hour_w;
  assign uni_parked_car        = uni_q;
  assign free_parked_car       = free_q;
  assign uni_vacated_space     = uni_vac;
  assign free_vacated_space    = free_vac;
  assign uni_is_vacated_space  = (uni_vac != '0);
  assign free_is_vacated_space = (free_vac != '0);
  assign ja_nist               = ja_q;
  assign faulty_exit           = fe_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Self-checking bench: directed scenarios plus biased random traffic over a full
// simulated day, compared against an arithmetic occupancy model.
module tb_parking_lot_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       car_entered = 1'b0;
  logic       is_uni_car_entered = 1'b0;
  logic       car_exited = 1'b0;
  logic       is_uni_car_exited = 1'b0;
  logic [4:0] hour;
  logic [9:0] uni_parked_car, free_parked_car;
  logic [9:0] uni_vacated_space, free_vacated_space;
  logic       uni_is_vacated_space, free_is_vacated_space;
  logic       ja_nist, faulty_exit;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: elapsed cycles since reset and the two occupancies.
  int m_cycles, m_uni, m_free;
  int m_ja, m_fe;

  parking_lot_ctrl dut (
    .clock                 (clock),
    .reset                 (reset),
    .car_entered           (car_entered),
    .is_uni_car_entered    (is_uni_car_entered),
    .car_exited            (car_exited),
    .is_uni_car_exited     (is_uni_car_exited),
    .hour                  (hour),
    .uni_parked_car        (uni_parked_car),
    .free_parked_car       (free_parked_car),
    .uni_vacated_space     (uni_vacated_space),
    .free_vacated_space    (free_vacated_space),
    .uni_is_vacated_space  (uni_is_vacated_space),
    .free_is_vacated_space (free_is_vacated_space),
    .ja_nist               (ja_nist),
    .faulty_exit           (faulty_exit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_hour();
    return (8 + m_cycles / 500) % 24;
  endfunction

  function automatic int m_free_cap(input int h);
    if (h <= 12) return 200;
    if (h == 13) return 250;
    if (h == 14) return 300;
    if (h == 15) return 350;
    return 500;
  endfunction

  function automatic int sat_sub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  task automatic model_reset();
    m_cycles = 0;
    m_uni    = 0;
    m_free   = 0;
    m_ja     = 0;
    m_fe     = 0;
  endtask

  task automatic model_edge(input bit e, input bit eu, input bit x, input bit xu);
    int fc, uc, uni0, free0;
    bit ent_ok, ex_ok;
    fc     = m_free_cap(m_hour());
    uc     = 700 - fc;
    uni0   = m_uni;
    free0  = m_free;
    ent_ok = e && (eu ? (uni0 < uc) : (free0 < fc));
    ex_ok  = x && (xu ? (uni0 > 0) : (free0 > 0));
    if (ent_ok) begin
      if (eu) m_uni++; else m_free++;
    end
    if (ex_ok) begin
      if (xu) m_uni--; else m_free--;
    end
    m_ja = (e && !ent_ok) ? 1 : 0;
    m_fe = (x && !ex_ok) ? 1 : 0;
    m_cycles++;
  endtask

  task automatic check_all(input string tag);
    int fc, uc, uv, fv;
    fc = m_free_cap(m_hour());
    uc = 700 - fc;
    uv = sat_sub(uc, m_uni);
    fv = sat_sub(fc, m_free);
    check({tag, "_hour"},       hour,                  m_hour());
    check({tag, "_uni_parked"}, uni_parked_car,        m_uni);
    check({tag, "_free_parked"},free_parked_car,       m_free);
    check({tag, "_uni_vac"},    uni_vacated_space,     uv);
    check({tag, "_free_vac"},   free_vacated_space,    fv);
    check({tag, "_uni_is_vac"}, uni_is_vacated_space,  (uv != 0) ? 1 : 0);
    check({tag, "_free_is_vac"},free_is_vacated_space, (fv != 0) ? 1 : 0);
    check({tag, "_ja_nist"},    ja_nist,               m_ja);
    check({tag, "_faulty_exit"},faulty_exit,           m_fe);
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic step(input bit e, input bit eu, input bit x, input bit xu);
    car_entered        = e;
    is_uni_car_entered = eu;
    car_exited         = x;
    is_uni_car_exited  = xu;
    @(posedge clock);
    model_edge(e, eu, x, xu);
    #1;
  endtask

  task automatic do_reset();
    car_entered = 1'b0;
    car_exited  = 1'b0;
    reset       = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    bit e, eu, x, xu;

    // 1: reset state
    do_reset();
    check("t1_hour", hour, 8);
    check("t1_uni_vac", uni_vacated_space, 500);
    check("t1_free_vac", free_vacated_space, 200);
    check_all("t1");

    // 2: uni entry, free exit on empty lot, uni exit
    step(1, 1, 0, 0);
    check("t2_uni_parked", uni_parked_car, 1);
    check("t2_uni_vac", uni_vacated_space, 499);
    check_all("t2a");
    step(0, 0, 1, 0);
    check("t2_faulty_free", faulty_exit, 1);
    check_all("t2b");
    step(0, 0, 1, 1);
    check("t2_uni_back", uni_vacated_space, 500);
    check_all("t2c");

    // 3: free entry, uni exit on empty, free exit
    step(1, 0, 0, 0);
    check("t3_free_vac", free_vacated_space, 199);
    check_all("t3a");
    step(0, 0, 1, 1);
    check("t3_faulty_uni", faulty_exit, 1);
    check_all("t3b");
    step(0, 0, 1, 0);
    check("t3_free_back", free_vacated_space, 200);
    check_all("t3c");

    // 4: idle through the afternoon capacity steps
    while (m_cycles < 4000) begin
      step(0, 0, 0, 0);
      check_all("t4");
      if (m_cycles == 2500) begin
        check("t4_hour13", hour, 13);
        check("t4_free_vac_h13", free_vacated_space, 250);
        check("t4_uni_vac_h13", uni_vacated_space, 450);
      end
      if (m_cycles == 3000) check("t4_free_vac_h14", free_vacated_space, 300);
      if (m_cycles == 3500) check("t4_free_vac_h15", free_vacated_space, 350);
    end
    check("t4_free_vac_h16", free_vacated_space, 500);

    // 5: fill the public area and overrun by one
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1, 0, 0, 0);
      check_all("t5_fill");
    end
    check("t5_free_parked", free_parked_car, 200);
    check("t5_free_vac0", free_vacated_space, 0);
    check("t5_free_is_vac0", free_is_vacated_space, 0);
    step(1, 0, 0, 0);
    check("t5_ja_nist", ja_nist, 1);
    check("t5_still200", free_parked_car, 200);
    step(0, 0, 0, 0);
    check("t5_ja_clear", ja_nist, 0);

    // 6: simultaneous same-category entry/exit, then asynchronous reset
    do_reset();
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    check("t6_uni3", uni_parked_car, 3);
    check("t6_no_ja", ja_nist, 0);
    check("t6_no_fe", faulty_exit, 0);
    check_all("t6");
    car_entered        = 1'b1;
    is_uni_car_entered = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_uni", uni_parked_car, 0);
    check("t6_async_free", free_parked_car, 0);
    check("t6_async_hour", hour, 8);

    // 7: entry-heavy random traffic over a full day, crossing capacity shrinks
    do_reset();
    for (int i = 0; i < 13500; i++) begin
      e  = ($urandom_range(99) < 55);
      eu = $urandom_range(1);
      x  = ($urandom_range(99) < 30);
      xu = $urandom_range(1);
      step(e, eu, x, xu);
      check_all("rnd_fill");
    end

    // 8: exit-heavy random traffic to drain and provoke illegal exits
    for (int i = 0; i < 3000; i++) begin
      e  = ($urandom_range(99) < 15);
      eu = $urandom_range(1);
      x  = ($urandom_range(99) < 70);
      xu = $urandom_range(1);
      step(e, eu, x, xu);
      check_all("rnd_drain");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
